// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline: operand forwarding, multi-cycle
// load-use stall, branch flush and saturating stall/flush event counters.
module pipeline_hazard_ctrl #(
   parameter int REG_AW     = 5,
   parameter int LOAD_STALL = 1,
   parameter int CNT_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] Rs1_D,
   input  logic [REG_AW-1:0] Rs2_D,
   input  logic [REG_AW-1:0] Rs1_E,
   input  logic [REG_AW-1:0] Rs2_E,
   input  logic [REG_AW-1:0] RD_E,
   input  logic              RegWriteE,
   input  logic              ResultSrcE,
   input  logic [REG_AW-1:0] RD_M,
   input  logic              RegWriteM,
   input  logic [REG_AW-1:0] RD_W,
   input  logic              RegWriteW,
   input  logic              PCSrcE,
   input  logic              perf_clr,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE,
   output logic              StallF,
   output logic              StallD,
   output logic              FlushD,
   output logic              FlushE,
   output logic [CNT_W-1:0]  StallCount,
   output logic [CNT_W-1:0]  FlushCount
);

   typedef enum logic {IDLE, WAIT} state_t;

   // The first stall cycle is spent in IDLE, so WAIT covers the remaining LOAD_STALL-1.
   localparam logic [3:0] WCNT_INIT = (LOAD_STALL > 1) ? 4'(LOAD_STALL - 2) : 4'd0;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t             state_q, state_d;
   logic [3:0]         wcnt_q, wcnt_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
   logic               lw_haz;
   logic               stall_int, flush_d_int, flush_e_int;
   logic [1:0]         fwd_a, fwd_b;

   assign lw_haz = ResultSrcE & RegWriteE & (RD_E != '0) & ((RD_E == Rs1_D) | (RD_E == Rs2_D));

   always_comb begin
      fwd_a = 2'b00;
      if (RegWriteM && (RD_M != '0) && (RD_M == Rs1_E))      fwd_a = 2'b10;
      else if (RegWriteW && (RD_W != '0) && (RD_W == Rs1_E)) fwd_a = 2'b01;
      fwd_b = 2'b00;
      if (RegWriteM && (RD_M != '0) && (RD_M == Rs2_E))      fwd_b = 2'b10;
      else if (RegWriteW && (RD_W != '0) && (RD_W == Rs2_E)) fwd_b = 2'b01;
   end

   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      stall_int   = 1'b0;
      flush_d_int = 1'b0;
      flush_e_int = 1'b0;
      if (PCSrcE) begin
         flush_d_int = 1'b1;
         flush_e_int = 1'b1;
         state_d     = IDLE;
         wcnt_d      = 4'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (lw_haz) begin
                  stall_int   = 1'b1;
                  flush_e_int = 1'b1;
                  if (LOAD_STALL > 1) begin
                     state_d = WAIT;
                     wcnt_d  = WCNT_INIT;
                  end
               end
            end
            WAIT: begin
               stall_int   = 1'b1;
               flush_e_int = 1'b1;
               if (wcnt_q == 4'd0) state_d = IDLE;
               else                wcnt_d  = wcnt_q - 4'd1;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (perf_clr) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (stall_int && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_ONE;
         if (PCSrcE && (flush_cnt_q != '1))    flush_cnt_d = flush_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         wcnt_q      <= 4'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Combinational outputs are forced low for as long as reset is held.
   assign ForwardAE  = rst ? fwd_a : 2'b00;
   assign ForwardBE  = rst ? fwd_b : 2'b00;
   assign StallF     = rst & stall_int;
   assign StallD     = rst & stall_int;
   assign FlushD     = rst & flush_d_int;
   assign FlushE     = rst & flush_e_int;
   assign StallCount = stall_cnt_q;
   assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: two instances (LOAD_STALL=3/CNT_W=4 and LOAD_STALL=1/CNT_W=32)
// driven in parallel and compared each cycle with a remaining-stall-cycles model.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic       reg_write_e, result_src_e, reg_write_m, reg_write_w, pc_src_e, perf_clr;

   logic [1:0]  fa_a, fb_a, fa_b, fb_b;
   logic        sf_a, sd_a, fd_a, fe_a, sf_b, sd_b, fd_b, fe_b;
   logic [3:0]  scnt_a, fcnt_a;
   logic [31:0] scnt_b, fcnt_b;

   int     n_cmp = 0;
   int     n_err = 0;
   int     rem_a = 0, rem_b = 0;
   longint sc_a = 0, fc_a = 0, sc_b = 0, fc_b = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.REG_AW(5), .LOAD_STALL(3), .CNT_W(4)) dut_a (
      .clk(clk), .rst(rst), .Rs1_D(rs1_d), .Rs2_D(rs2_d), .Rs1_E(rs1_e), .Rs2_E(rs2_e),
      .RD_E(rd_e), .RegWriteE(reg_write_e), .ResultSrcE(result_src_e), .RD_M(rd_m),
      .RegWriteM(reg_write_m), .RD_W(rd_w), .RegWriteW(reg_write_w), .PCSrcE(pc_src_e),
      .perf_clr(perf_clr), .ForwardAE(fa_a), .ForwardBE(fb_a), .StallF(sf_a), .StallD(sd_a),
      .FlushD(fd_a), .FlushE(fe_a), .StallCount(scnt_a), .FlushCount(fcnt_a));

   pipeline_hazard_ctrl #(.REG_AW(5), .LOAD_STALL(1), .CNT_W(32)) dut_b (
      .clk(clk), .rst(rst), .Rs1_D(rs1_d), .Rs2_D(rs2_d), .Rs1_E(rs1_e), .Rs2_E(rs2_e),
      .RD_E(rd_e), .RegWriteE(reg_write_e), .ResultSrcE(result_src_e), .RD_M(rd_m),
      .RegWriteM(reg_write_m), .RD_W(rd_w), .RegWriteW(reg_write_w), .PCSrcE(pc_src_e),
      .perf_clr(perf_clr), .ForwardAE(fa_b), .ForwardBE(fb_b), .StallF(sf_b), .StallD(sd_b),
      .FlushD(fd_b), .FlushE(fe_b), .StallCount(scnt_b), .FlushCount(fcnt_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
      if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
      if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit lw_ref();
      return result_src_e && reg_write_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
   endfunction

   function automatic bit stall_ref(input int rem);
      return rst && !pc_src_e && (rem > 0 || lw_ref());
   endfunction

   task automatic check_dut(input string n, input int rem, input longint sc, input longint fc,
                            input logic [1:0] fa, input logic [1:0] fb, input logic sf,
                            input logic sd, input logic fd, input logic fe,
                            input logic [31:0] scnt, input logic [31:0] fcnt);
      bit st;
      st = stall_ref(rem);
      chk({n, ".ForwardAE"}, 32'(fa), rst ? 32'(fwd_ref(rs1_e)) : 32'd0);
      chk({n, ".ForwardBE"}, 32'(fb), rst ? 32'(fwd_ref(rs2_e)) : 32'd0);
      chk({n, ".StallF"}, 32'(sf), 32'(st));
      chk({n, ".StallD"}, 32'(sd), 32'(st));
      chk({n, ".FlushD"}, 32'(fd), 32'(rst && pc_src_e));
      chk({n, ".FlushE"}, 32'(fe), 32'(rst && (pc_src_e || st)));
      chk({n, ".StallCount"}, scnt, rst ? 32'(sc) : 32'd0);
      chk({n, ".FlushCount"}, fcnt, rst ? 32'(fc) : 32'd0);
   endtask

   // Model works in "stall cycles still owed" rather than states.
   task automatic model_edge(input int ls, input longint maxc, inout int rem,
                             inout longint sc, inout longint fc);
      bit st;
      st = stall_ref(rem);
      if (!rst) begin
         rem = 0; sc = 0; fc = 0;
      end else begin
         if (perf_clr) begin
            sc = 0; fc = 0;
         end else begin
            if (st && sc < maxc) sc++;
            if (pc_src_e && fc < maxc) fc++;
         end
         if (pc_src_e)        rem = 0;
         else if (rem > 0)    rem--;
         else if (lw_ref())   rem = ls - 1;
      end
   endtask

   task automatic step();
      #2;
      check_dut("A", rem_a, sc_a, fc_a, fa_a, fb_a, sf_a, sd_a, fd_a, fe_a, 32'(scnt_a), 32'(fcnt_a));
      check_dut("B", rem_b, sc_b, fc_b, fa_b, fb_b, sf_b, sd_b, fd_b, fe_b, scnt_b, fcnt_b);
      $display("cyc t=%0t rst=%0b haz=%0b br=%0b clr=%0b | A st=%0b sc=%0d fc=%0d | B st=%0b sc=%0d fc=%0d",
               $time, rst, lw_ref(), pc_src_e, perf_clr, sd_a, scnt_a, fcnt_a, sd_b, scnt_b, fcnt_b);
      @(posedge clk);
      model_edge(3, 15, rem_a, sc_a, fc_a);
      model_edge(1, 64'hFFFF_FFFF, rem_b, sc_b, fc_b);
      #1;
   endtask

   task automatic idle_inputs();
      rst = 1'b1;
      {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
      {reg_write_e, result_src_e, reg_write_m, reg_write_w, pc_src_e, perf_clr} = '0;
   endtask

   task automatic load_hazard();
      rd_e = 5'd7; reg_write_e = 1'b1; result_src_e = 1'b1; rs2_d = 5'd7;
   endtask

   task automatic clear_counters();
      idle_inputs(); perf_clr = 1'b1; step(); perf_clr = 1'b0;
   endtask

   initial begin
      // Reset with every input pointing at a hazard: outputs must still read zero.
      idle_inputs();
      rst = 1'b0;
      load_hazard();
      rd_m = 5'd5; reg_write_m = 1'b1; rs1_e = 5'd5; pc_src_e = 1'b1;
      step(); step();
      idle_inputs();
      step();

      // Forwarding priority on both operands.
      for (int op = 0; op < 2; op++) begin
         idle_inputs();
         rd_m = 5'd5; rd_w = 5'd5; reg_write_m = 1'b1; reg_write_w = 1'b1;
         if (op == 0) rs1_e = 5'd5; else rs2_e = 5'd5;
         step();
         reg_write_m = 1'b0; step();
         rd_w = 5'd0; step();
      end

      // Single load-use hazard.
      clear_counters();
      load_hazard(); step();
      idle_inputs(); step(); step(); step();
      chk("lu.StallCountA", 32'(scnt_a), 32'd3);
      chk("lu.StallCountB", scnt_b, 32'd1);

      // Reset during the second stall cycle aborts the sequence.
      load_hazard(); step();
      idle_inputs(); rst = 1'b0;
      #1;
      chk("rstwait.StallD", 32'(sd_a), 32'd0);
      chk("rstwait.StallCount", 32'(scnt_a), 32'd0);
      step();
      idle_inputs(); step(); step();

      // Branch and load-use in the same cycle.
      clear_counters();
      load_hazard(); pc_src_e = 1'b1; step();
      idle_inputs(); step();
      chk("br.FlushCountA", 32'(fcnt_a), 32'd1);
      chk("br.StallCountA", 32'(scnt_a), 32'd0);

      // Continuous stalling saturates the 4-bit counter, then clear wins over increment.
      clear_counters();
      load_hazard();
      for (int i = 0; i < 20; i++) step();
      chk("sat.StallCountA", 32'(scnt_a), 32'd15);
      perf_clr = 1'b1; step();
      chk("sat.clr", 32'(scnt_a), 32'd0);
      idle_inputs(); step(); step(); step();

      // Randomised traffic with small register numbers so matches are frequent.
      for (int i = 0; i < 3000; i++) begin
         rst          = ($urandom_range(0, 99) != 0);
         rs1_d        = 5'($urandom_range(0, 3));
         rs2_d        = 5'($urandom_range(0, 3));
         rs1_e        = 5'($urandom_range(0, 3));
         rs2_e        = 5'($urandom_range(0, 3));
         rd_e         = 5'($urandom_range(0, 3));
         rd_m         = 5'($urandom_range(0, 3));
         rd_w         = 5'($urandom_range(0, 3));
         reg_write_e  = 1'($urandom_range(0, 1));
         result_src_e = 1'($urandom_range(0, 1));
         reg_write_m  = 1'($urandom_range(0, 1));
         reg_write_w  = 1'($urandom_range(0, 1));
         pc_src_e     = ($urandom_range(0, 7) == 0);
         perf_clr     = ($urandom_range(0, 63) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised hazard controller for the 5-stage RV32 pipeline, the successor to the fixed single-cycle forwarding block. It sits beside the fetch/decode/execute/memory/writeback stages. It produces the forwarding selects, the stall and flush controls, and a multi-cycle load-use stall sequence for data memories slower than one cycle. It also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- REG_AW, 5, register-address width
- LOAD_STALL, 1, stall cycles per load-use hazard; legal range 1..15
- CNT_W, 32, performance-counter width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- Rs1_D, Rs2_D  in  REG_AW  source registers of the instruction in Decode
- Rs1_E, Rs2_E  in  REG_AW  source registers of the instruction in Execute
- RD_E  in  REG_AW  destination register in Execute
- RegWriteE, ResultSrcE  in  1  Execute writes a register / Execute is a load
- RD_M, RegWriteM  in  REG_AW, 1  Memory-stage destination / write enable
- RD_W, RegWriteW  in  REG_AW, 1  Writeback-stage destination / write enable
- PCSrcE  in  1  taken branch or jump resolved in Execute
- perf_clr  in  1  synchronous clear of both counters
- ForwardAE, ForwardBE  out  2  ALU operand select: 00 register file, 01 ResultW, 10 ALU_ResultM
- StallF, StallD  out  1  hold PC / hold the IF/ID register
- FlushD, FlushE  out  1  bubble the IF/ID / ID/EX register
- StallCount, FlushCount  out  CNT_W  saturating event counters

## Operation
- **Forwarding** (combinational):
  - ForwardAE = 10 if RegWriteM and RD_M≠0 and RD_M==Rs1_E.
  - Otherwise ForwardAE = 01 if RegWriteW and RD_W≠0 and RD_W==Rs1_E.
  - Otherwise ForwardAE = 00.
  - ForwardBE uses the same rules with Rs2_E.
  - Memory stage has priority over Writeback.
- **Load-use detect:** lwHaz = ResultSrcE & RegWriteE & (RD_E≠0) & (RD_E==Rs1_D | RD_E==Rs2_D).
- **FSM states:** IDLE, WAIT. Down-counter wcnt is 4 bits wide.
  - IDLE with lwHaz and no PCSrcE:
    - Assert StallF, StallD and FlushE this cycle.
    - If LOAD_STALL>1, go to WAIT with wcnt=LOAD_STALL-2. Otherwise stay in IDLE.
  - WAIT:
    - Assert StallF, StallD and FlushE every cycle. lwHaz is ignored, because E holds a bubble.
    - If wcnt==0, go to IDLE. Otherwise decrement wcnt.
- **Branch flush:** PCSrcE asserts FlushD and FlushE in the same cycle.
  - PCSrcE wins over any stall: StallF=StallD=0 that cycle, and the FSM is forced to IDLE.
- **StallCount:** +1 every cycle StallD=1.
- **FlushCount:** +1 every cycle PCSrcE=1.
- **Counter rules:**
  - Both counters saturate at all-ones.
  - perf_clr zeroes both counters and takes priority over an increment in the same cycle.

## Timing
- Forward, stall and flush outputs are combinational from the current inputs and the state, valid in the same cycle.
- FSM, wcnt and counters update on the rising edge of clk.
- Total stall per load-use hazard is exactly LOAD_STALL consecutive cycles; the hazard-free back-to-back rate is 1 instruction per cycle.
- **Reset:** while rst=0, all outputs are 0, FSM=IDLE, wcnt=0 and counters=0, irrespective of the clock.
  - Reset asserted mid-WAIT aborts the sequence immediately.
  - Outputs resume normal evaluation on the first cycle after release.
- **Simultaneous events:**
  - lwHaz with PCSrcE: flush only, no stall, no StallCount increment; FlushCount +1.
  - A counter at all-ones with an increment holds its value.

## Test plan
- Forwarding: RD_M=RD_W=Rs1_E=5 with RegWriteM=RegWriteW=1 -> ForwardAE=10. Then RegWriteM=0 -> 01. Then RD_W=0 -> 00. Repeat on Rs2_E/ForwardBE.
- Load-use, LOAD_STALL=1: load to x7 in E, Rs2_D=7 -> StallF=StallD=FlushE=1 for exactly 1 cycle, then 0; StallCount=1.
- Load-use, LOAD_STALL=3: same stimulus -> stall and flush held 3 consecutive cycles, then IDLE; StallCount=3. Asserting rst in the 2nd cycle -> all outputs 0 at once, StallCount=0.
- Branch vs hazard: lwHaz and PCSrcE in the same cycle -> FlushD=FlushE=1, StallF=StallD=0, FlushCount=1, StallCount=0, FSM stays IDLE.
- Counters, CNT_W=4: 20 stall cycles -> StallCount stops at 15. perf_clr in the same cycle as a stall -> StallCount=0.
